wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue_pkg.sv | 6 +
 rtl/wb_queue_if.sv | 26 ++
 rtl/wb_queue_match.sv | 33 +++
 rtl/wb_queue.sv | 80 ++++++++
 tb/tb_wb_queue.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_queue_pkg.sv
// Shared register-file geometry for the writeback queue.
// These are the single source of the register data and address widths.
package wb_queue_pkg;
  localparam int REG_BUS      = 32;
  localparam int REG_NUM_LOG2 = 5;
endpackage

// File: rtl/wb_queue_if.sv
// Producer handshake and regfile write port of the writeback queue.
interface wb_queue_if
  import wb_queue_pkg::*;
#(
  parameter int DW = REG_BUS,
  parameter int AW = REG_NUM_LOG2
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          wr_hold;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  modport slave (
    input  in_valid, in_addr, in_data, wr_hold,
    output in_ready, we, waddr, wdata
  );

  modport master (
    output in_valid, in_addr, in_data, wr_hold,
    input  in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/wb_queue_match.sv
// Youngest-match search over the occupied queue entries for one lookup port.
module wb_match #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic [DEPTH-1:0][AW-1:0]   ent_addr,
  input  logic [DEPTH-1:0][DW-1:0]   ent_data,
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic [AW-1:0]              key,
  output logic                       hit,
  output logic [DW-1:0]              data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match seen wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (key != '0 && CW'(k) < count && ent_addr[idx] == key) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end
endmodule

// File: rtl/wb_queue.sv
// In-order writeback buffer in front of the regfile write port, with
// two operand lookups that forward the newest pending value per register.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = REG_BUS,
  parameter int AW    = REG_NUM_LOG2
) (
  input  logic                   clk,
  input  logic                   rst,
  wb_queue_if.slave              wb,
  input  logic [AW-1:0]          lk_addr1,
  input  logic [AW-1:0]          lk_addr2,
  output logic                   lk_hit1,
  output logic                   lk_hit2,
  output logic [DW-1:0]          lk_data1,
  output logic [DW-1:0]          lk_data2,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic [PW-1:0]            rd_ptr, wr_ptr;
  logic                     push, enq, retire;

  // Full is judged before any same-cycle retire: no bypass into a full queue.
  assign wb.in_ready = (count < CW'(DEPTH));
  assign push        = wb.in_valid && wb.in_ready;
  assign enq         = push && (wb.in_addr != '0);
  assign wb.we       = (count != '0) && !wb.wr_hold;
  assign retire      = wb.we;
  assign wb.waddr    = ent_addr[rd_ptr];
  assign wb.wdata    = ent_data[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq)    wr_ptr <= wr_ptr + 1'b1;
      if (retire) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(enq) - CW'(retire);
    end
  end

  // Storage is left uncleared; occupancy is defined solely by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[wr_ptr] <= wb.in_addr;
      ent_data[wr_ptr] <= wb.in_data;
    end
  end

  logic [1:0][AW-1:0] key;
  logic [1:0]         hit;
  logic [1:0][DW-1:0] val;

  assign key = {lk_addr2, lk_addr1};

  for (genvar l = 0; l < 2; l++) begin : g_lk
    wb_match #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_match (
      .ent_addr (ent_addr),
      .ent_data (ent_data),
      .head     (rd_ptr),
      .count    (count),
      .key      (key[l]),
      .hit      (hit[l]),
      .data     (val[l])
    );
  end

  assign lk_hit1  = hit[0];
  assign lk_hit2  = hit[1];
  assign lk_data1 = val[0];
  assign lk_data2 = val[1];
endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue with a scoreboard of pending writebacks.
module tb_wb_queue;
  import wb_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_queue_if #(.DW(DW), .AW(AW)) wb ();

  logic [AW-1:0]          lk_addr1, lk_addr2;
  logic                   lk_hit1, lk_hit2;
  logic [DW-1:0]          lk_data1, lk_data2;
  logic [$clog2(DEPTH):0] count;

  wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb       (wb.slave),
    .lk_addr1 (lk_addr1),
    .lk_addr2 (lk_addr2),
    .lk_hit1  (lk_hit1),
    .lk_hit2  (lk_hit2),
    .lk_data1 (lk_data1),
    .lk_data2 (lk_data2),
    .count    (count)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t sb[$];
  int   total  = 0;
  int   passed = 0;
  bit   acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void lk_model(input logic [AW-1:0] k, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    if (k != '0)
      foreach (sb[i])
        if (sb[i].a == k) begin
          h = 1'b1;
          d = sb[i].d;
        end
  endfunction

  // Runs at the falling edge: checks the cycle's outputs, then applies the
  // retire/push the coming rising edge will perform.
  task automatic monitor();
    int            n;
    bit            exp_we, exp_rdy;
    logic          h;
    logic [DW-1:0] d;
    n       = sb.size();
    exp_we  = (n != 0) && !wb.wr_hold;
    exp_rdy = (n < DEPTH);
    chk("count", count, n);
    chk("we", wb.we, exp_we);
    chk("in_ready", wb.in_ready, exp_rdy);
    lk_model(lk_addr1, h, d);
    chk("lk_hit1", lk_hit1, h);
    chk("lk_data1", lk_data1, d);
    lk_model(lk_addr2, h, d);
    chk("lk_hit2", lk_hit2, h);
    chk("lk_data2", lk_data2, d);
    if (exp_we) begin
      chk("waddr", wb.waddr, sb[0].a);
      chk("wdata", wb.wdata, sb[0].d);
      void'(sb.pop_front());
    end
    acc = wb.in_valid && exp_rdy;
    if (acc && wb.in_addr != '0) sb.push_back({wb.in_addr, wb.in_data});
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst) monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb.in_valid = 1'b1;
    wb.in_addr  = a;
    wb.in_data  = d;
    tick();
    wb.in_valid = 1'b0;
  endtask

  initial begin
    int nxt;
    wb.in_valid = 1'b0;
    wb.in_addr  = '0;
    wb.in_data  = '0;
    wb.wr_hold  = 1'b0;
    lk_addr1    = 5'd3;
    lk_addr2    = '0;

    // Reset state
    #12;
    chk("rst_we", wb.we, 1'b0);
    chk("rst_in_ready", wb.in_ready, 1'b1);
    chk("rst_count", count, 0);
    chk("rst_lk_hit1", lk_hit1, 1'b0);
    chk("rst_lk_data1", lk_data1, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single push, written the next cycle
    offer(5'd3, 32'hAAAA_0003);
    tick();
    chk("single_count", count, 0);

    // Fill under hold, reject 5th, then drain in order
    wb.wr_hold = 1'b1;
    for (int i = 1; i <= 4; i++) offer(AW'(i), 32'h1000_0000 + i);
    chk("full_count", count, 4);
    chk("full_in_ready", wb.in_ready, 1'b0);
    offer(5'd5, 32'h5);
    wb.wr_hold = 1'b0;
    repeat (4) tick();
    chk("drain_count", count, 0);

    // Youngest match wins; addr 0 never hits
    lk_addr1   = 5'd7;
    lk_addr2   = '0;
    wb.wr_hold = 1'b1;
    offer(5'd7, 32'h11);
    offer(5'd7, 32'h22);
    chk("young_hit1", lk_hit1, 1'b1);
    chk("young_data1", lk_data1, 32'h22);
    chk("zero_hit2", lk_hit2, 1'b0);
    chk("zero_data2", lk_data2, 0);
    lk_addr2 = 5'd9;
    #1 chk("miss_hit2", lk_hit2, 1'b0);
    lk_addr2 = 5'd7;
    #1 chk("dup_data2", lk_data2, 32'h22);
    wb.wr_hold = 1'b0;
    repeat (3) tick();

    // Push to r0 is dropped
    offer(5'd0, 32'hFFFF);
    repeat (2) tick();
    chk("r0_count", count, 0);
    chk("r0_we", wb.we, 1'b0);

    // Full queue streaming with in_valid held high across pointer wrap
    wb.wr_hold = 1'b1;
    lk_addr1   = 5'd10;
    lk_addr2   = 5'd15;
    for (int i = 0; i < 4; i++) offer(AW'(10 + i), 32'h4000 + i);
    nxt         = 14;
    wb.in_valid = 1'b1;
    wb.wr_hold  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wb.in_addr = AW'(nxt);
      wb.in_data = 32'h4000 + nxt - 10;
      tick();
      if (acc) nxt++;
    end
    wb.in_valid = 1'b0;
    repeat (6) tick();
    chk("stream_count", count, 0);

    // Asynchronous reset mid-operation
    wb.wr_hold = 1'b1;
    lk_addr1   = 5'd21;
    for (int i = 0; i < 3; i++) offer(AW'(20 + i), 32'h7000 + i);
    chk("pre_rst_count", count, 3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_we", wb.we, 1'b0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_in_ready", wb.in_ready, 1'b1);
    chk("mid_rst_lk_hit1", lk_hit1, 1'b0);
    chk("mid_rst_lk_data1", lk_data1, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    wb.wr_hold = 1'b0;
    offer(5'd5, 32'h55);
    tick();
    chk("post_rst_count", count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
